cntr_mod: RTL and testbench

CNTR_MOD -- requirements
Module: cntr_mod

---
 rtl/cntr_pkg.sv | 16 +
 rtl/cntr_presc.sv | 47 ++++
 rtl/cntr_mod.sv | 96 +++++++++
 tb/tb_cntr_mod.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cntr_pkg.sv
// Shared definitions for the cntr_mod counter: default sizes and terminal-value helper.
package cntr_pkg;

   localparam int unsigned DEF_WIDTH = 16;
   localparam int unsigned DEF_PRESC = 1;

   // Highest value the counter reaches: modulo-1, or all ones when modulo is 0.
   function automatic longint unsigned calc_top(input int unsigned     width,
                                                input longint unsigned modulo);
      if (modulo != 0) begin
         return modulo - 64'd1;
      end
      return (64'd1 << width) - 64'd1;
   endfunction

endpackage

// File: rtl/cntr_presc.sv
// Prescaler for cntr_mod: counts ce cycles 0..PRESC-1 and flags the last one.
// With PRESC=1 no state is built and tick is always 1.
module cntr_presc
   import cntr_pkg::*;
#(
   parameter int unsigned PRESC = DEF_PRESC
) (
   input  logic clk,
   input  logic rst,
   input  logic ce,
   input  logic clr,
   output logic tick
);

   if (PRESC <= 1) begin : g_bypass
      logic unused_in;
      assign unused_in = ^{clk, rst, ce, clr};
      assign tick      = 1'b1;
   end else begin : g_cnt
      localparam int unsigned   CW   = $clog2(PRESC);
      localparam logic [CW-1:0] LAST = CW'(PRESC - 1);

      logic [CW-1:0] cnt_q, cnt_d;

      // Next count: clear wins, otherwise advance on ce and wrap after the last value.
      always_comb begin
         cnt_d = cnt_q;
         if (clr) begin
            cnt_d = '0;
         end else if (ce) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
         end
      end

      // Prescale count register.
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign tick = (cnt_q == LAST);
   end

endmodule

// File: rtl/cntr_mod.sv
// Up/down modulo counter with prescaler, load, wrap/saturate and terminal count.
// Define CNTR_MOD_CAPTURE_EN to build the capture register behind cap/cap_val;
// otherwise cap is ignored and cap_val is tied to 0.
module cntr_mod
   import cntr_pkg::*;
#(
   parameter int unsigned     WIDTH  = DEF_WIDTH,
   parameter longint unsigned MODULO = 0,
   parameter int unsigned     PRESC  = DEF_PRESC,
   parameter int unsigned     SAT    = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             up,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   input  logic             cap,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             ovf,
   output logic [WIDTH-1:0] cap_val
);

   localparam logic [WIDTH-1:0] TOP      = WIDTH'(calc_top(WIDTH, MODULO));
   localparam bit               SATURATE = (SAT != 0);

   logic [WIDTH-1:0] out_q, out_d;
   logic             ovf_q, ovf_d;
   logic             tick, step, at_bound;

   // A load restarts the prescale so the first step after it takes a full PRESC ce cycles.
   cntr_presc #(
      .PRESC(PRESC)
   ) u_presc (
      .clk (clk),
      .rst (rst),
      .ce  (ce),
      .clr (ld),
      .tick(tick)
   );

   assign step     = ce & tick;
   assign at_bound = up ? (out_q == TOP) : (out_q == '0);
   assign tc       = step & at_bound;

   // Next count and overflow: load beats step; a step at the bound wraps or saturates.
   always_comb begin
      out_d = out_q;
      ovf_d = 1'b0;
      if (ld) begin
         out_d = (ld_val > TOP) ? TOP : ld_val;
      end else if (step) begin
         ovf_d = at_bound;
         if (up) begin
            out_d = at_bound ? (SATURATE ? TOP : '0) : out_q + 1'b1;
         end else begin
            out_d = at_bound ? (SATURATE ? '0 : TOP) : out_q - 1'b1;
         end
      end
   end

   // Count and overflow-pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         out_q <= out_d;
         ovf_q <= ovf_d;
      end
   end

   assign out = out_q;
   assign ovf = ovf_q;

`ifdef CNTR_MOD_CAPTURE_EN
   logic [WIDTH-1:0] cap_q;

   // Capture the pre-edge count, so a same-cycle load or step does not leak in.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_q <= '0;
      end else if (cap) begin
         cap_q <= out_q;
      end
   end

   assign cap_val = cap_q;
`else
   logic unused_cap;
   assign unused_cap = cap;
   assign cap_val    = '0;
`endif

endmodule

// File: tb/tb_cntr_mod.sv
// Self-checking bench for cntr_mod: four configurations driven by shared stimulus,
// checked against a behavioural model, a constant vector table and directed sequences.
module tb_cntr_mod;

   localparam int N = 4;
   // Configurations: d0 16-bit full range, d1 mod-10 wrap, d2 mod-10 saturate, d3 8-bit PRESC=5.
   localparam longint unsigned P_TOP   [N] = '{65535, 9, 9, 255};
   localparam longint unsigned P_PRESC [N] = '{1, 1, 1, 5};
   localparam bit              P_SAT   [N] = '{1'b0, 1'b0, 1'b1, 1'b0};
   localparam longint unsigned P_MASK  [N] = '{65535, 31, 31, 255};
`ifdef CNTR_MOD_CAPTURE_EN
   localparam bit CAP_EN = 1'b1;
`else
   localparam bit CAP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, ce, up, ld, cap;
   logic [15:0] lv;

   logic [15:0] out0, cv0;
   logic [4:0]  out1, cv1, out2, cv2;
   logic [7:0]  out3, cv3;
   logic        tc0, tc1, tc2, tc3, ovf0, ovf1, ovf2, ovf3;

   always #5 clk = ~clk;

   cntr_mod #(.WIDTH(16), .MODULO(0), .PRESC(1), .SAT(0)) d0 (
      .clk(clk), .rst(rst), .ce(ce), .up(up), .ld(ld), .ld_val(lv), .cap(cap),
      .out(out0), .tc(tc0), .ovf(ovf0), .cap_val(cv0));
   cntr_mod #(.WIDTH(5), .MODULO(10), .PRESC(1), .SAT(0)) d1 (
      .clk(clk), .rst(rst), .ce(ce), .up(up), .ld(ld), .ld_val(lv[4:0]), .cap(cap),
      .out(out1), .tc(tc1), .ovf(ovf1), .cap_val(cv1));
   cntr_mod #(.WIDTH(5), .MODULO(10), .PRESC(1), .SAT(1)) d2 (
      .clk(clk), .rst(rst), .ce(ce), .up(up), .ld(ld), .ld_val(lv[4:0]), .cap(cap),
      .out(out2), .tc(tc2), .ovf(ovf2), .cap_val(cv2));
   cntr_mod #(.WIDTH(8), .MODULO(0), .PRESC(5), .SAT(0)) d3 (
      .clk(clk), .rst(rst), .ce(ce), .up(up), .ld(ld), .ld_val(lv[7:0]), .cap(cap),
      .out(out3), .tc(tc3), .ovf(ovf3), .cap_val(cv3));

   logic [31:0] a_out [N];
   logic [31:0] a_cap [N];
   logic        a_tc  [N];
   logic        a_ovf [N];

   assign a_out[0] = 32'(out0);
   assign a_out[1] = 32'(out1);
   assign a_out[2] = 32'(out2);
   assign a_out[3] = 32'(out3);
   assign a_cap[0] = 32'(cv0);
   assign a_cap[1] = 32'(cv1);
   assign a_cap[2] = 32'(cv2);
   assign a_cap[3] = 32'(cv3);
   assign a_tc[0]  = tc0;
   assign a_tc[1]  = tc1;
   assign a_tc[2]  = tc2;
   assign a_tc[3]  = tc3;
   assign a_ovf[0] = ovf0;
   assign a_ovf[1] = ovf1;
   assign a_ovf[2] = ovf2;
   assign a_ovf[3] = ovf3;

   // Reference model state: count value, qualified-ce count, last ovf, captured value.
   longint unsigned m_out [N];
   longint unsigned m_pc  [N];
   longint unsigned m_cap [N];
   bit              m_ovf [N];
   bit              s_tc  [N];

   int n_tests = 0;
   int n_fail  = 0;

   function automatic bit exp_tc(input int i);
      bit tick_now = (m_pc[i] == P_PRESC[i] - 1);
      return ce && tick_now && (up ? (m_out[i] == P_TOP[i]) : (m_out[i] == 0));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_out[i] = 0;
         m_pc[i]  = 0;
         m_cap[i] = 0;
         m_ovf[i] = 1'b0;
      end
   endtask

   task automatic model_update();
      for (int i = 0; i < N; i++) begin
         longint unsigned o   = m_out[i];
         longint unsigned top = P_TOP[i];
         longint unsigned lvm = {48'd0, lv} & P_MASK[i];
         if (rst) begin
            m_out[i] = 0;
            m_pc[i]  = 0;
            m_cap[i] = 0;
            m_ovf[i] = 1'b0;
         end else begin
            if (CAP_EN && cap) m_cap[i] = o;
            m_ovf[i] = 1'b0;
            if (ld) begin
               m_out[i] = (lvm > top) ? top : lvm;
               m_pc[i]  = 0;
            end else if (ce) begin
               if (m_pc[i] + 1 == P_PRESC[i]) begin
                  m_pc[i] = 0;
                  if (up) begin
                     m_ovf[i] = (o == top);
                     m_out[i] = P_SAT[i] ? ((o < top) ? o + 1 : top) : (o + 1) % (top + 1);
                  end else begin
                     m_ovf[i] = (o == 0);
                     m_out[i] = P_SAT[i] ? ((o > 0) ? o - 1 : 0) : (o + top) % (top + 1);
                  end
               end else begin
                  m_pc[i] = m_pc[i] + 1;
               end
            end
         end
      end
   endtask

   // Drive one cycle, check tc before the edge and registered outputs after it.
   task automatic do_cycle(input bit r, input bit c, input bit u, input bit l,
                           input logic [15:0] v, input bit cp);
      @(negedge clk);
      rst = r; ce = c; up = u; ld = l; lv = v; cap = cp;
      #1;
      for (int i = 0; i < N; i++) begin
         s_tc[i] = a_tc[i];
         n_tests++;
         if (a_tc[i] !== exp_tc(i)) begin
            n_fail++;
            $display("FAIL tc d%0d t=%0t: got %b want %b", i, $time, a_tc[i], exp_tc(i));
         end
      end
      model_update();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         n_tests++;
         if (a_out[i] !== 32'(m_out[i]) || a_ovf[i] !== m_ovf[i] ||
             a_cap[i] !== 32'(m_cap[i])) begin
            n_fail++;
            $display("FAIL regs d%0d t=%0t: got out=%0d ovf=%b cap=%0d want out=%0d ovf=%b cap=%0d",
                     i, $time, a_out[i], a_ovf[i], a_cap[i], m_out[i], m_ovf[i], m_cap[i]);
         end
      end
   endtask

   task automatic check_val(input string name, input longint unsigned got,
                            input longint unsigned want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s t=%0t: got %0d want %0d", name, $time, got, want);
      end
   endtask

   typedef struct {
      bit          r, c, u, l;
      logic [15:0] v;
      bit          tc1, tc2;
      logic [4:0]  o1, o2;
      bit          ov1, ov2;
   } vec_t;

   vec_t tbl [11];

   initial begin
      int tc_cnt, ovf_cnt, tc_at;

      // Expected values for d1 (mod 10, wrap) and d2 (mod 10, saturate); tc is pre-edge.
      tbl[0]  = '{1, 1, 1, 1, 16'd5,  0, 0, 5'd0, 5'd0, 0, 0};  // rst beats ld
      tbl[1]  = '{0, 1, 1, 1, 16'd20, 0, 0, 5'd9, 5'd9, 0, 0};  // ld clamps, no step
      tbl[2]  = '{0, 1, 1, 0, 16'd0,  1, 1, 5'd0, 5'd9, 1, 1};
      tbl[3]  = '{0, 1, 1, 0, 16'd0,  0, 1, 5'd1, 5'd9, 0, 1};
      tbl[4]  = '{0, 1, 0, 0, 16'd0,  0, 0, 5'd0, 5'd8, 0, 0};
      tbl[5]  = '{0, 1, 0, 0, 16'd0,  1, 0, 5'd9, 5'd7, 1, 0};
      tbl[6]  = '{0, 0, 0, 0, 16'd0,  0, 0, 5'd9, 5'd7, 0, 0};  // ce=0 holds
      tbl[7]  = '{0, 0, 0, 1, 16'd0,  0, 0, 5'd0, 5'd0, 0, 0};  // ld without ce
      tbl[8]  = '{0, 1, 0, 0, 16'd0,  1, 1, 5'd9, 5'd0, 1, 1};
      tbl[9]  = '{0, 1, 1, 1, 16'd3,  1, 0, 5'd3, 5'd3, 0, 0};  // ld beats step at TOP
      tbl[10] = '{0, 1, 1, 0, 16'd0,  0, 0, 5'd4, 5'd4, 0, 0};

      rst = 1'b1; ce = 1'b0; up = 1'b1; ld = 1'b0; lv = '0; cap = 1'b0;
      repeat (2) @(posedge clk);
      model_reset();

      // Reset state, with ld/ce/cap asserted alongside reset.
      do_cycle(1, 1, 1, 1, 16'd33, 1);
      for (int i = 0; i < N; i++) begin
         check_val($sformatf("reset_out_d%0d", i), a_out[i], 0);
         check_val($sformatf("reset_ovf_d%0d", i), a_ovf[i], 0);
         check_val($sformatf("reset_cap_d%0d", i), a_cap[i], 0);
      end

      for (int k = 0; k < 11; k++) begin
         do_cycle(tbl[k].r, tbl[k].c, tbl[k].u, tbl[k].l, tbl[k].v, 1'b0);
         check_val($sformatf("vec%0d_tc1", k), s_tc[1], tbl[k].tc1);
         check_val($sformatf("vec%0d_tc2", k), s_tc[2], tbl[k].tc2);
         check_val($sformatf("vec%0d_out1", k), a_out[1], tbl[k].o1);
         check_val($sformatf("vec%0d_out2", k), a_out[2], tbl[k].o2);
         check_val($sformatf("vec%0d_ovf1", k), a_ovf[1], tbl[k].ov1);
         check_val($sformatf("vec%0d_ovf2", k), a_ovf[2], tbl[k].ov2);
      end

      // Capture alongside a step: the old count is captured.
      do_cycle(0, 0, 1, 1, 16'd7, 0);
      do_cycle(0, 1, 1, 0, 16'd0, 1);
      check_val("cap_step_out", a_out[1], 8);
      check_val("cap_step_val", a_cap[1], CAP_EN ? 7 : 0);

      // Prescale by 5, then a 3-cycle ce gap mid-prescale delays the step by 3.
      do_cycle(1, 0, 1, 0, 16'd0, 0);
      repeat (4) do_cycle(0, 1, 1, 0, 16'd0, 0);
      check_val("presc_before_tick", a_out[3], 0);
      do_cycle(0, 1, 1, 0, 16'd0, 0);
      check_val("presc_first_step", a_out[3], 1);
      repeat (2) do_cycle(0, 1, 1, 0, 16'd0, 0);
      repeat (3) do_cycle(0, 0, 1, 0, 16'd0, 0);
      repeat (2) do_cycle(0, 1, 1, 0, 16'd0, 0);
      check_val("presc_gap_hold", a_out[3], 1);
      do_cycle(0, 1, 1, 0, 16'd0, 0);
      check_val("presc_gap_step", a_out[3], 2);

      // Full 16-bit sweep: one tc at 65535, one ovf, back to 0; d1 follows 0..9,0.
      do_cycle(1, 0, 1, 0, 16'd0, 0);
      tc_cnt = 0; ovf_cnt = 0; tc_at = -1;
      for (int k = 0; k < 65536; k++) begin
         do_cycle(0, 1, 1, 0, 16'd0, 0);
         if (s_tc[0]) begin
            tc_cnt++;
            tc_at = k;
         end
         if (a_ovf[0]) ovf_cnt++;
         if (k < 11) check_val($sformatf("mod10_seq%0d", k), a_out[1], (k + 1) % 10);
      end
      check_val("sweep_wrap_out", a_out[0], 0);
      check_val("sweep_tc_count", tc_cnt, 1);
      check_val("sweep_tc_at", tc_at, 65535);
      check_val("sweep_ovf_count", ovf_cnt, 1);

      // Random traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         do_cycle($urandom_range(0, 99) == 0, ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0,
                  16'($urandom), $urandom_range(0, 4) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
